// File: rtl/basketball_pkg.sv
// Shared state codes, screen limits and pixel type for the shot simulator.
// Used by the session controller, kinematic and VGA blocks.
package basketball_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_AIM    = 3'd1;
   localparam logic [2:0] ST_FLIGHT = 3'd2;
   localparam logic [2:0] ST_RESULT = 3'd3;
   localparam logic [2:0] ST_OVER   = 3'd4;

   localparam int SCREEN_W_DEF = 640;
   localparam int FLOOR_Y_DEF  = 470;

   typedef logic [9:0] pix_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ clocks.
// Holding restart keeps the count at zero so a full period follows release.
module tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);

   logic [W-1:0] r_cnt;
   logic         w_term;

   assign w_term = (r_cnt == TERM);
   assign tick   = w_term & ~restart;

   always_ff @(posedge clk) begin
      if (rst || restart || w_term) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/shot_session_ctrl.sv
// Game-session sequencer: aim under a shot clock, launch, judge the flight
// against the hoop window and count makes/attempts until the game ends.
module shot_session_ctrl
   import basketball_pkg::*;
#(
   parameter int CLK_HZ            = 100_000_000,
   parameter int SHOT_CLOCK_S      = 24,
   parameter int MAX_SHOTS         = 10,
   parameter int HOOP_X            = 560,
   parameter int HOOP_Y            = 120,
   parameter int HOOP_HALF_W       = 16,
   parameter int SCREEN_W          = SCREEN_W_DEF,
   parameter int FLOOR_Y           = FLOOR_Y_DEF,
   parameter int MAX_FLIGHT_FRAMES = 255,
   parameter int RESULT_FRAMES     = 60
) (
   input  logic       CLK100MHZ,
   input  logic       rst,
   input  logic       btn_shoot,
   input  logic       frame_tick,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   output logic       launch,
   output logic       kin_rst,
   output logic [2:0] state,
   output logic [7:0] score,
   output logic [7:0] attempts,
   output logic [4:0] shot_clock,
   output logic       made_flag,
   output logic       game_over
);

   localparam logic [4:0]         SC_RELOAD = 5'(SHOT_CLOCK_S);
   localparam logic [7:0]         MAX_ATT   = 8'(MAX_SHOTS);
   localparam logic [8:0]         FLIGHT_TO = 9'(MAX_FLIGHT_FRAMES);
   localparam logic [8:0]         RES_DONE  = 9'(RESULT_FRAMES);
   localparam logic [9:0]         RIM_Y     = 10'(HOOP_Y);
   localparam logic [9:0]         FLOOR_P   = 10'(FLOOR_Y);
   localparam logic [9:0]         X_LIM     = 10'(SCREEN_W - 1);
   localparam logic signed [10:0] HOOP_X_S  = 11'(HOOP_X);
   localparam logic signed [10:0] HALF_W_S  = 11'(HOOP_HALF_W);

   logic r_meta, r_sync, r_sync_d, r_rise;

   logic [2:0] r_state;
   logic [7:0] r_score, r_attempts;
   logic [4:0] r_shot_clock;
   logic       r_made, r_launch, r_kin_rst, r_game_over;
   pix_t       r_prev_y;
   logic [7:0] r_flight_cnt, r_res_cnt;

   logic [2:0] w_state;
   logic [7:0] w_score, w_attempts;
   logic [4:0] w_shot_clock;
   logic       w_made, w_launch;
   logic [7:0] w_flight_cnt, w_res_cnt;

   logic                w_tick, w_restart;
   logic signed [10:0]  w_dx, w_adx;
   logic                w_make, w_miss;
   logic [8:0]          w_flight_inc, w_res_inc;

   // Extra registered stage on the edge pulse gives a fixed 4-edge launch latency
   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
         r_rise   <= 1'b0;
      end else begin
         r_meta   <= btn_shoot;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_rise   <= r_sync & ~r_sync_d;
      end
   end

   assign w_restart = (r_state != ST_AIM);

   tick_gen #(
      .CLK_HZ(CLK_HZ)
   ) u_tick (
      .clk    (CLK100MHZ),
      .rst    (rst),
      .restart(w_restart),
      .tick   (w_tick)
   );

   assign w_dx         = $signed({1'b0, ball_x}) - HOOP_X_S;
   assign w_adx        = w_dx[10] ? -w_dx : w_dx;
   assign w_make       = (r_prev_y < RIM_Y) && (ball_y >= RIM_Y)
                         && (w_adx <= HALF_W_S);
   assign w_flight_inc = {1'b0, r_flight_cnt} + 9'd1;
   assign w_res_inc    = {1'b0, r_res_cnt} + 9'd1;
   assign w_miss       = (ball_y >= FLOOR_P) || (ball_x >= X_LIM)
                         || (w_flight_inc == FLIGHT_TO);

   always_comb begin
      w_state      = r_state;
      w_score      = r_score;
      w_attempts   = r_attempts;
      w_shot_clock = r_shot_clock;
      w_made       = r_made;
      w_launch     = 1'b0;
      w_flight_cnt = r_flight_cnt;
      w_res_cnt    = r_res_cnt;
      case (r_state)
         ST_IDLE: begin
            w_score      = '0;
            w_attempts   = '0;
            w_shot_clock = '0;
            w_made       = 1'b0;
            if (r_rise) begin
               w_state      = ST_AIM;
               w_shot_clock = SC_RELOAD;
            end
         end
         ST_AIM: begin
            if (r_rise) begin
               w_state      = ST_FLIGHT;
               w_launch     = 1'b1;
               w_attempts   = r_attempts + 8'd1;
               w_flight_cnt = '0;
            end else if (w_tick) begin
               if (r_shot_clock <= 5'd1) begin
                  w_shot_clock = '0;
                  w_state      = ST_RESULT;
                  w_attempts   = r_attempts + 8'd1;
                  w_made       = 1'b0;
                  w_res_cnt    = '0;
               end else begin
                  w_shot_clock = r_shot_clock - 5'd1;
               end
            end
         end
         ST_FLIGHT: begin
            if (frame_tick) begin
               w_flight_cnt = w_flight_inc[7:0];
               if (w_make) begin
                  w_score   = r_score + 8'd1;
                  w_made    = 1'b1;
                  w_state   = ST_RESULT;
                  w_res_cnt = '0;
               end else if (w_miss) begin
                  w_made    = 1'b0;
                  w_state   = ST_RESULT;
                  w_res_cnt = '0;
               end
            end
         end
         ST_RESULT: begin
            if (frame_tick) begin
               w_res_cnt = w_res_inc[7:0];
               if (w_res_inc >= RES_DONE) begin
                  w_res_cnt = '0;
                  if (r_attempts >= MAX_ATT) begin
                     w_state = ST_OVER;
                  end else begin
                     w_state      = ST_AIM;
                     w_shot_clock = SC_RELOAD;
                  end
               end
            end
         end
         ST_OVER: begin
            if (r_rise) begin
               w_state      = ST_AIM;
               w_score      = '0;
               w_attempts   = '0;
               w_made       = 1'b0;
               w_shot_clock = SC_RELOAD;
            end
         end
         default: begin
            w_state      = ST_IDLE;
            w_score      = '0;
            w_attempts   = '0;
            w_shot_clock = '0;
            w_made       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_score      <= '0;
         r_attempts   <= '0;
         r_shot_clock <= '0;
         r_made       <= 1'b0;
         r_launch     <= 1'b0;
         r_kin_rst    <= 1'b1;
         r_game_over  <= 1'b0;
         r_prev_y     <= '0;
         r_flight_cnt <= '0;
         r_res_cnt    <= '0;
      end else begin
         r_state      <= w_state;
         r_score      <= w_score;
         r_attempts   <= w_attempts;
         r_shot_clock <= w_shot_clock;
         r_made       <= w_made;
         r_launch     <= w_launch;
         r_kin_rst    <= (w_state != ST_AIM) && (w_state != ST_FLIGHT);
         r_game_over  <= (w_state == ST_OVER);
         r_flight_cnt <= w_flight_cnt;
         r_res_cnt    <= w_res_cnt;
         if (frame_tick) begin
            r_prev_y <= ball_y;
         end
      end
   end

   assign launch     = r_launch;
   assign kin_rst    = r_kin_rst;
   assign state      = r_state;
   assign score      = r_score;
   assign attempts   = r_attempts;
   assign shot_clock = r_shot_clock;
   assign made_flag  = r_made;
   assign game_over  = r_game_over;

endmodule

// File: doc/shot_session_ctrl.md
# shot_session_ctrl

Game-session sequencer for the basketball shot simulator, sitting between the button/accelerometer front end, the `kinematic` projectile block and the VGA/seven-segment displays. It runs a parametrised multi-attempt game:
- aim under a shot clock;
- launch the ball;
- judge each flight against a hoop window;
- count makes and attempts until `MAX_SHOTS` is reached.

It replaces direct button-to-`kinematic` wiring with a state machine that owns `launch`/`kin_rst`.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: clock frequency, used for the 1 s tick.
- `SHOT_CLOCK_S`, 24: shot-clock reload value in seconds, 1..31.
- `MAX_SHOTS`, 10: attempts per game, 1..255.
- `HOOP_X`, 560: hoop centre x in pixels.
- `HOOP_Y`, 120: hoop rim y in pixels (y grows downward).
- `HOOP_HALF_W`, 16: make window is ±`HOOP_HALF_W` px around `HOOP_X`.
- `SCREEN_W`, 640: horizontal screen limit in pixels.
- `FLOOR_Y`, 470: floor line in pixels.
- `MAX_FLIGHT_FRAMES`, 255: flight timeout in frames.
- `RESULT_FRAMES`, 60: frames to hold the result display.

Ports:
- `CLK100MHZ`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `btn_shoot`  in  1  raw shoot button (BTNC), asynchronous.
- `frame_tick`  in  1  one-cycle pulse per VGA frame.
- `ball_x`  in  10  ball position from `kinematic`.
- `ball_y`  in  10  ball position from `kinematic`.
- `launch`  out  1  one-cycle launch pulse to `kinematic`.
- `kin_rst`  out  1  holds `kinematic` at its start position.
- `state`  out  3  current FSM state.
- `score`  out  8  made shots.
- `attempts`  out  8  attempts used.
- `shot_clock`  out  5  seconds remaining.
- `made_flag`  out  1  last attempt result, 1 = make.
- `game_over`  out  1  high in OVER.

## Operation
- **Button conditioning:** `btn_shoot` passes through a 2-FF synchroniser and then a rising-edge detector, giving the pulse `btn_rise`. Holding the button produces exactly one `btn_rise`.
- **States:** IDLE=0, AIM=1, FLIGHT=2, RESULT=3, OVER=4.
- **IDLE:**
  - Outputs: `kin_rst`=1, all counters 0.
  - `btn_rise` → AIM.
  - On entry to AIM: `shot_clock`=`SHOT_CLOCK_S`, `kin_rst`=0.
- **AIM:**
  - `shot_clock` decrements on each 1 s tick.
  - `btn_rise` → FLIGHT. In the same cycle: `launch`=1, `attempts`+1, flight-frame counter cleared.
  - Tick taking `shot_clock` from 1 to 0 → RESULT. In the same cycle: `attempts`+1, `made_flag`=0.
  - If `btn_rise` and expiry occur in the same cycle, the launch wins.
- **FLIGHT:** evaluated only on `frame_tick`, using the previous-frame `y` register.
  - **Make:** prev_y < `HOOP_Y` ≤ `ball_y` and |`ball_x` − `HOOP_X`| ≤ `HOOP_HALF_W`. Result: `score`+1, `made_flag`=1, go to RESULT.
  - **Miss:** `ball_y` ≥ `FLOOR_Y`, or `ball_x` ≥ `SCREEN_W`−1, or flight frames = `MAX_FLIGHT_FRAMES`. Result: `made_flag`=0, go to RESULT.
  - If make and miss conditions hold on the same tick, the make wins.
  - `btn_rise` is ignored.
- **RESULT:**
  - `kin_rst`=1; count `RESULT_FRAMES` frame ticks.
  - When the count is done: if `attempts` = `MAX_SHOTS` → OVER; otherwise → AIM with `shot_clock` reloaded.
- **OVER:**
  - `game_over`=1, `kin_rst`=1; `score`/`attempts` are held for display.
  - `btn_rise` → AIM. `score`, `attempts`, `made_flag` clear and `shot_clock` reloads in the same edge.
- **Arithmetic:** unsigned throughout. The |dx| compare uses 11-bit signed difference. Counters cannot exceed `MAX_SHOTS`, so no wrap is possible.
- **Out-of-range state codes** (5–7) → IDLE on the next edge.

## Timing
- **Reset values** (next edge with `rst`=1): `state`=IDLE, `kin_rst`=1, `launch`=0, `score`=0, `attempts`=0, `shot_clock`=0, `made_flag`=0, `game_over`=0. Synchroniser, second prescaler and frame counters are also cleared.
- **Reset mid-operation** (e.g. mid-FLIGHT) aborts with no score update.
- **Button latency:** `btn_shoot` high, first sampled at edge k → `launch` high during the cycle after edge k+3, for exactly 1 cycle.
- **Outputs:** all registered; `state` changes on the same edge as the counter updates.
- **1 s tick:** prescaler counts 0..`CLK_HZ`−1 and pulses at terminal count. The prescaler restarts at 0 on every entry to AIM, so the first decrement comes a full second after entry.
- **`frame_tick` while not in FLIGHT/RESULT:** only updates prev_y.

## Structure
- **Package `basketball_pkg`:**
  - state enum/localparams;
  - `SCREEN_W`/`FLOOR_Y` defaults;
  - 10-bit pixel coordinate typedef, shared with `kinematic` and `VGA`.
- **Sub-module `tick_gen`:** parametrised prescaler with `restart` input, `CLK_HZ` parameter and `tick` output. Reused by the shot clock display.
- **Remainder:** sync/edge logic plus the FSM, in one file.

## Test plan
Sim parameters: `CLK_HZ`=1000, `RESULT_FRAMES`=2, `MAX_SHOTS`=3, `frame_tick` every 10 cycles.
- **Reset:** hold `rst` 3 cycles → all outputs at reset values; `state`=0.
- **Launch pulse:** press `btn_shoot` 50 cycles in AIM → `launch` is a single 1-cycle pulse 4 edges after the press; `attempts`=1; `state`=2.
- **Make:**
  - Stimulus: `ball_y` 110→125 with `ball_x`=570.
  - Response: `score`=1, `made_flag`=1, RESULT.
  - Repeat with `ball_x`=577 → miss path is not taken and no score change.
- **Shot-clock expiry:**
  - Stimulus: no press in AIM.
  - Response: `shot_clock` counts 24→0 over 24000 cycles, then `attempts`+1, `made_flag`=0, RESULT.
  - Press in the expiry cycle → launch wins.
- **Game over:**
  - Stimulus: three attempts.
  - Response: OVER, `game_over`=1, `attempts`=3.
  - `btn_rise` → AIM with counters cleared and `shot_clock`=24.
- **Reset mid-FLIGHT:** assert `rst` mid-FLIGHT with a make frame pending → `score` stays 0, `state`=IDLE.
